sdram_read_ppfifo: RTL and testbench

SDRAM_READ_PPFIFO -- requirements
Module: sdram_read_ppfifo

---
 rtl/sdram_read_ppfifo.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_read_ppfifo.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_ppfifo.sv
// Ping-pong read FIFO: two buffers alternate between the SDRAM read engine and a consumer.
// Define SDRAM_PPFIFO_ERR_EN to add the sticky error[1:0] output.
module sdram_read_ppfifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_reset,
  output logic [1:0]            write_ready,
  input  logic [1:0]            write_activate,
  output logic [23:0]           write_fifo_size,
  input  logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  starved,
  output logic                  read_ready,
  input  logic                  read_activate,
  output logic [23:0]           read_count,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] read_data,
`ifdef SDRAM_PPFIFO_ERR_EN
  output logic [1:0]            error,
`endif
  output logic [3:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_FILLED  = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  // Ownership handshake: a side owns a buffer from the edge after its activate
  // rises until the edge after it falls; strobes only act on an owned buffer.
  buf_state_t                 state_q [2];
  buf_state_t                 state_d [2];
  logic [CW-1:0]              cnt_q [2];
  logic [CW-1:0]              cnt_d [2];
  logic [ADDRESS_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic                       newest_q, newest_d;
  logic                       rd_wait_q, rd_wait_d;
  logic [1:0]                 wr_act_q;
  logic                       rd_act_q;
  logic [DATA_WIDTH-1:0]      mem_q [2][DEPTH];

  logic [1:0]                 wr_rise, wr_fall, filled, reading, rel;
  logic                       wr_both, rd_rise, rd_fall, any_filled, any_reading;
  logic                       rd_idx, old_idx;
  logic [CW-1:0]              rd_left;
  logic                       mem_we, mem_wbuf;
  logic [ADDRESS_WIDTH-1:0]   mem_waddr;
`ifdef SDRAM_PPFIFO_ERR_EN
  logic                       drop_wr, bad_rd;
  logic [1:0]                 err_q, err_d;
`endif

  always_comb begin
    wr_rise = write_activate & ~wr_act_q;
    wr_fall = wr_act_q & ~write_activate;
    wr_both = &write_activate;
    rd_rise = read_activate & ~rd_act_q;
    rd_fall = rd_act_q & ~read_activate;
    for (int i = 0; i < 2; i++) begin
      filled[i]  = (state_q[i] == BUF_FILLED);
      reading[i] = (state_q[i] == BUF_READING);
    end
    any_filled  = |filled;
    any_reading = |reading;
    rd_idx      = reading[1];
    // With both buffers filled the older one is whichever was not stamped newest.
    old_idx     = (&filled) ? ~newest_q : filled[1];
    rd_left     = cnt_q[rd_idx];
  end

  assign write_ready = rst_n ? (~write_activate &
                                {state_q[1] == BUF_EMPTY, state_q[0] == BUF_EMPTY}) : 2'b11;
  assign write_fifo_size = 24'(DEPTH);
  assign read_ready      = ~read_activate & any_filled;
  assign starved         = ~any_filled & (~any_reading | (rd_left == '0));
  assign read_data       = any_reading ? mem_q[rd_idx][rd_ptr_q] : '0;
  assign dbg_state       = {state_q[1], state_q[0]};

  always_comb begin
    read_count = '0;
    if (read_activate && any_reading) read_count = 24'(rd_left);
    else if (!read_activate && any_filled) read_count = 24'(cnt_q[old_idx]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    newest_d  = newest_q;
    rd_wait_d = rd_wait_q;
    rel       = 2'b00;
    mem_we    = 1'b0;
    mem_wbuf  = 1'b0;
    mem_waddr = '0;
`ifdef SDRAM_PPFIFO_ERR_EN
    drop_wr   = 1'b0;
    bad_rd    = read_strobe && !(any_reading && rd_left != '0);
`endif

    if (read_strobe && any_reading && rd_left != '0) begin
      cnt_d[rd_idx] = rd_left - CW'(1);
      rd_ptr_d      = rd_ptr_q + ADDRESS_WIDTH'(1);
    end
    if (rd_fall && any_reading) begin
      state_d[rd_idx] = BUF_EMPTY;
      cnt_d[rd_idx]   = '0;
      rd_ptr_d        = '0;
    end

    for (int i = 0; i < 2; i++) begin
      if (state_q[i] == BUF_WRITING) begin
        if (wr_fall[i]) begin
          if (cnt_q[i] != '0) begin
            state_d[i] = BUF_FILLED;
            newest_d   = 1'(i);
            rel[i]     = 1'b1;
          end else begin
            state_d[i] = BUF_EMPTY;
          end
        end else if (write_strobe && write_activate[i] && !wr_both) begin
          if (cnt_q[i] != DEPTH_C) begin
            mem_we    = 1'b1;
            mem_wbuf  = 1'(i);
            mem_waddr = cnt_q[i][ADDRESS_WIDTH-1:0];
            cnt_d[i]  = cnt_q[i] + CW'(1);
          end
`ifdef SDRAM_PPFIFO_ERR_EN
          else drop_wr = 1'b1;
`endif
        end
      end else if (wr_rise[i] && !wr_both &&
                   (state_q[i] == BUF_EMPTY || (reading[i] && rd_fall))) begin
        state_d[i] = BUF_WRITING;
        cnt_d[i]   = '0;
      end
    end

    // A reader that arrives before any data waits and grabs the next buffer to fill,
    // including one the writer releases in this very cycle.
    if (read_activate && !any_reading && (rd_rise || rd_wait_q)) begin
      if (any_filled) begin
        state_d[old_idx] = BUF_READING;
        rd_ptr_d         = '0;
        rd_wait_d        = 1'b0;
      end else if (rel != 2'b00) begin
        state_d[~rel[0]] = BUF_READING;
        rd_ptr_d         = '0;
        rd_wait_d        = 1'b0;
      end else begin
        rd_wait_d = 1'b1;
      end
    end else if (!read_activate) begin
      rd_wait_d = 1'b0;
    end

    if (fifo_reset) begin
      for (int i = 0; i < 2; i++) begin
        state_d[i] = BUF_EMPTY;
        cnt_d[i]   = '0;
      end
      rd_ptr_d  = '0;
      newest_d  = 1'b0;
      rd_wait_d = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= BUF_EMPTY;
        cnt_q[i]   <= '0;
      end
      rd_ptr_q  <= '0;
      newest_q  <= 1'b0;
      rd_wait_q <= 1'b0;
      wr_act_q  <= 2'b00;
      rd_act_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      newest_q  <= newest_d;
      rd_wait_q <= rd_wait_d;
      wr_act_q  <= write_activate;
      rd_act_q  <= read_activate;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wbuf][mem_waddr] <= write_data;
  end

`ifdef SDRAM_PPFIFO_ERR_EN
  assign err_d = fifo_reset ? 2'b00 : (err_q | {bad_rd, drop_wr});
  assign error = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_sdram_read_ppfifo.sv
// Bench for sdram_read_ppfifo: directed ping-pong scenarios then random traffic,
// every cycle checked against a queue-per-buffer ownership model.
`timescale 1ns/1ps
module tb_sdram_read_ppfifo;

  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int S_EMPTY = 0, S_WRITING = 1, S_FILLED = 2, S_READING = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_reset = 1'b0;
  logic [1:0]    write_ready;
  logic [1:0]    write_activate = 2'b00;
  logic [23:0]   write_fifo_size;
  logic          write_strobe = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          starved;
  logic          read_ready;
  logic          read_activate = 1'b0;
  logic [23:0]   read_count;
  logic          read_strobe = 1'b0;
  logic [DW-1:0] read_data;
  logic [3:0]    dbg_state;
`ifdef SDRAM_PPFIFO_ERR_EN
  logic [1:0]    error;
`endif

  always #5 clk = ~clk;

  sdram_read_ppfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_reset      (fifo_reset),
    .write_ready     (write_ready),
    .write_activate  (write_activate),
    .write_fifo_size (write_fifo_size),
    .write_strobe    (write_strobe),
    .write_data      (write_data),
    .starved         (starved),
    .read_ready      (read_ready),
    .read_activate   (read_activate),
    .read_count      (read_count),
    .read_strobe     (read_strobe),
    .read_data       (read_data),
`ifdef SDRAM_PPFIFO_ERR_EN
    .error           (error),
`endif
    .dbg_state       (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_chk = 0;
  int            n_bad = 0;
  int            m_st [2];
  logic [DW-1:0] exp_q [2][$];
  int            m_order [$];
  int            m_reader;
  bit            m_wait;
  logic [1:0]    m_pw;
  logic          m_pr;
  logic [1:0]    m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_EMPTY;
      exp_q[i].delete();
    end
    m_order.delete();
    m_reader = -1;
    m_wait   = 1'b0;
    m_pw     = 2'b00;
    m_pr     = 1'b0;
    m_err    = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] rise, fall;
    logic       rrise, rfall, both, want;
    rise  = write_activate & ~m_pw;
    fall  = m_pw & ~write_activate;
    rrise = read_activate & ~m_pr;
    rfall = m_pr & ~read_activate;
    m_pw  = write_activate;
    m_pr  = read_activate;
    if (fifo_reset) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = S_EMPTY;
        exp_q[i].delete();
      end
      m_order.delete();
      m_reader = -1;
      m_wait   = 1'b0;
      m_err    = 2'b00;
      return;
    end
    both = (write_activate == 2'b11);
    if (read_strobe) begin
      if (m_reader >= 0 && exp_q[m_reader].size() > 0) void'(exp_q[m_reader].pop_front());
      else m_err[1] = 1'b1;
    end
    if (rfall && m_reader >= 0) begin
      m_st[m_reader] = S_EMPTY;
      exp_q[m_reader].delete();
      m_reader = -1;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == S_WRITING) begin
        if (fall[i]) begin
          if (exp_q[i].size() > 0) begin
            m_st[i] = S_FILLED;
            m_order.push_back(i);
          end else begin
            m_st[i] = S_EMPTY;
          end
        end else if (write_strobe && write_activate[i] && !both) begin
          if (exp_q[i].size() < DEPTH) exp_q[i].push_back(write_data);
          else m_err[0] = 1'b1;
        end
      end else if (rise[i] && !both && m_st[i] == S_EMPTY) begin
        m_st[i] = S_WRITING;
        exp_q[i].delete();
      end
    end
    want = read_activate && (m_reader < 0) && (rrise || m_wait);
    if (want) begin
      if (m_order.size() > 0) begin
        m_reader       = m_order.pop_front();
        m_st[m_reader] = S_READING;
        m_wait         = 1'b0;
      end else begin
        m_wait = 1'b1;
      end
    end else if (!read_activate) begin
      m_wait = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ewr;
    int         rc;
    logic       est;
    for (int i = 0; i < 2; i++) ewr[i] = (m_st[i] == S_EMPTY) && !write_activate[i];
    check("write_ready", write_ready, ewr);
    check("read_ready", read_ready, !read_activate && m_order.size() > 0);
    rc = 0;
    if (read_activate && m_reader >= 0) rc = exp_q[m_reader].size();
    else if (!read_activate && m_order.size() > 0) rc = exp_q[m_order[0]].size();
    check("read_count", read_count, rc);
    est = (m_order.size() == 0);
    if (m_reader >= 0) begin
      if (exp_q[m_reader].size() > 0) begin
        est = 1'b0;
        check("read_data", read_data, exp_q[m_reader][0]);
      end
    end
    check("starved", starved, est);
    check("fifo_size", write_fifo_size, DEPTH);
`ifdef SDRAM_PPFIFO_ERR_EN
    check("error", error, m_err);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] a_wact, input logic a_ract, input logic a_ws,
                      input logic [DW-1:0] a_wd, input logic a_rs, input logic a_frst);
    write_activate = a_wact;
    read_activate  = a_ract;
    write_strobe   = a_ws;
    write_data     = a_wd;
    read_strobe    = a_rs;
    fifo_reset     = a_frst;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic fill(input logic [1:0] sel, input int n, input logic [DW-1:0] base);
    step(sel, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) step(sel, 1'b0, 1'b1, base + DW'(k), 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_write_ready", write_ready, 2'b11);
    check("rst_read_ready", read_ready, 1'b0);
    check("rst_read_count", read_count, 0);
    check("rst_starved", starved, 1'b1);
    check("rst_read_data", read_data, 0);
`ifdef SDRAM_PPFIFO_ERR_EN
    check("rst_error", error, 2'b00);
`endif
    model_reset();
    write_activate = 2'b00;
    read_activate  = 1'b0;
    write_strobe   = 1'b0;
    read_strobe    = 1'b0;
    fifo_reset     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] rw;
  logic       rr;

  initial begin
    model_reset();
    #3;
    check("init_write_ready", write_ready, 2'b11);
    check("init_read_ready", read_ready, 1'b0);
    check("init_read_count", read_count, 0);
    check("init_starved", starved, 1'b1);
    check("init_read_data", read_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full buffer 0 then drain it.
    fill(2'b01, 16, 32'h1000);
    #1;
    check("fill16_write_ready", write_ready, 2'b10);
    check("fill16_read_ready", read_ready, 1'b1);
    check("fill16_read_count", read_count, 16);
    check("fill16_starved", starved, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check("drain_seq", read_data, 32'h1000 + k);
      step(2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    end
    #1;
    check("drain_read_count", read_count, 0);
    check("drain_starved", starved, 1'b1);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("drain_write_ready", write_ready, 2'b11);

    // Overflow: the 17th word is dropped.
    fill(2'b10, 17, 32'h2000);
    #1;
    check("over_read_count", read_count, 16);
`ifdef SDRAM_PPFIFO_ERR_EN
    check("over_error0", error[0], 1'b1);
`endif
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Two filled buffers are consumed oldest first.
    fill(2'b01, 3, 32'h3000);
    fill(2'b10, 5, 32'h3100);
    #1;
    check("pp_offer0", read_count, 3);
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("pp_own0_count", read_count, 3);
    check("pp_own0_data", read_data, 32'h3000);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("pp_own1_count", read_count, 5);
    check("pp_own1_data", read_data, 32'h3100);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Writer release and reader acquire in the same cycle.
    step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 32'h4000, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("xfer_read_count", read_count, 1);
    check("xfer_read_data", read_data, 32'h4000);
    check("xfer_starved", starved, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Waiting reader picks up the next buffer to fill.
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b1, 32'h5001, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("wait_read_count", read_count, 2);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-write.
    step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b01, 1'b0, 1'b1, 32'h6000 + k, 1'b0, 1'b0);
    write_strobe = 1'b1;
    async_reset();

    // Synchronous fifo_reset mid-write; held activate must not re-acquire.
    step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b01, 1'b0, 1'b1, 32'h7000 + k, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 32'h7004, 1'b0, 1'b1);
    #1;
    check("frst_read_count", read_count, 0);
    check("frst_starved", starved, 1'b1);
    check("frst_write_ready", write_ready, 2'b10);
    step(2'b01, 1'b0, 1'b1, 32'h7005, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("frst_write_ready_idle", write_ready, 2'b11);
    check("frst_starved_idle", starved, 1'b1);

    // Random traffic.
    rw = 2'b00;
    rr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) rw[0] = ~rw[0];
      if ($urandom_range(0, 7) == 0) rw[1] = ~rw[1];
      if ($urandom_range(0, 5) == 0) rr = ~rr;
      step(rw, rr, 1'($urandom_range(0, 1)), DW'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
